// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct, ALU/mux selects,
// FSM state enum and the packed control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
`ifdef MIPS_CTRL_TRAP_EN
    , S_TRAP   = 4'd12
`endif
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       bus_err;
  } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational dispatch decoder: opcode/funct -> first post-DECODE state, or illegal flag.
// Zero latency, no handshake.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output state_t              target,
  output logic                illegal
);

  always_comb begin
    target  = S_FETCH;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_ADD) target = S_EXEC_R;
        else                 illegal = 1'b1;
      end
      OP_ADDI:        target = S_EXEC_I;
      OP_LW, OP_SW:   target = S_MEM_ADDR;
      OP_BEQ, OP_BNE: target = S_BRANCH;
      OP_J:           target = S_JUMP;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: Moore control word per state, memory states stall on mem_ready
// with a bounded wait (bus_err). Build macro MIPS_CTRL_TRAP_EN parks faults in a sticky TRAP state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 2,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_en,
  output logic [1:0]          pc_src,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [3:0]          state_o,
  output logic                illegal,
  output logic                bus_err
);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  state_t              dec_target;
  logic                dec_illegal;
  logic                mem_wait, timeout;
  ctrl_t               ctrl;
`ifdef MIPS_CTRL_TRAP_EN
  logic                trap_ill_q, trap_ill_d, trap_bus_q, trap_bus_d;
`endif

  mips_ctrl_decode #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W)
  ) u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .target  (dec_target),
    .illegal (dec_illegal)
  );

  assign mem_wait = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !mem_ready;
  assign timeout  = (WAIT_MAX > 0) && mem_wait && (int'(wait_q) == WAIT_MAX - 1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    ctrl    = '0;
`ifdef MIPS_CTRL_TRAP_EN
    trap_ill_d = trap_ill_q;
    trap_bus_d = trap_bus_q;
`endif
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
        op_d           = opcode;
        if (dec_illegal) begin
          ctrl.illegal = 1'b1;
`ifdef MIPS_CTRL_TRAP_EN
          trap_ill_d = 1'b1;
          state_d    = S_TRAP;
`else
          state_d    = S_FETCH;
`endif
        end else begin
          state_d = dec_target;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_FUNCT;
        state_d        = S_WB_R;
      end
      S_WB_R: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
        if (state_q == S_EXEC_I)  state_d = S_WB_I;
        else if (op_q == OP_SW)   state_d = S_MEM_WR;
        else                      state_d = S_MEM_RD;
      end
      S_WB_I: begin
        ctrl.reg_write = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_RT;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.pc_en     = (op_q == OP_BNE) ? ~zero : zero;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_en  = 1'b1;
        state_d     = S_FETCH;
      end
`ifdef MIPS_CTRL_TRAP_EN
      S_TRAP: begin
        ctrl.illegal = trap_ill_q;
        ctrl.bus_err = trap_bus_q;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Timeout implies mem_ready=0, so no IR/PC/register write is already in flight.
    if (timeout) begin
      ctrl.bus_err = 1'b1;
`ifdef MIPS_CTRL_TRAP_EN
      trap_bus_d = 1'b1;
      state_d    = S_TRAP;
`else
      state_d    = S_FETCH;
`endif
    end else if (mem_wait) begin
      wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end

    if (reset) ctrl = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      op_q    <= '0;
`ifdef MIPS_CTRL_TRAP_EN
      trap_ill_q <= 1'b0;
      trap_bus_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
`ifdef MIPS_CTRL_TRAP_EN
      trap_ill_q <= trap_ill_d;
      trap_bus_q <= trap_bus_d;
`endif
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign pc_src     = ctrl.pc_src;
  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign ir_write   = ctrl.ir_write;
  assign reg_dst    = ctrl.reg_dst;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ALUOP_W'(ctrl.alu_op);
  assign illegal    = ctrl.illegal;
  assign bus_err    = ctrl.bus_err;
  assign state_o    = reset ? 4'd0 : state_q;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle FSM control unit for the MIPS core. It replaces the single-decode control path with a per-state Moore control word. It decodes the opcode and funct fields from the instruction register and handshakes with memory through mem_ready. It drives PC, IR, register-file, ALU and memory control for add, addi, lw, sw, j, beq and bne.

Parameters:
OPCODE_W, 6, opcode field width
FUNCT_W, 6, funct field width
ALUOP_W, 2, ALU operation code width
WAIT_MAX, 15, max cycles a memory state waits for mem_ready before bus error; 0 = wait forever
WAIT_W, 4, wait counter width; must satisfy 2^WAIT_W > WAIT_MAX

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  IR[31:26], valid from DECODE onward
funct  in  FUNCT_W  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
pc_en  out  1  PC load enable
pc_src  out  2  PC mux select: 00 ALU result, 01 ALUOut (branch target), 10 jump target
iord  out  1  memory address select: 0 PC, 1 ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load enable
reg_dst  out  1  write register select: 1 rd, 0 rt
mem_to_reg  out  1  writeback data select: 1 memory data, 0 ALUOut
reg_write  out  1  register-file write enable
alu_src_a  out  1  ALU A select: 0 PC, 1 rs
alu_src_b  out  2  ALU B select: 00 rt, 01 const 4, 10 sign-extended immediate, 11 shifted immediate
alu_op  out  ALUOP_W  ALU op: 00 add, 01 sub, 10 use funct
state_o  out  4  current state encoding, for debug
illegal  out  1  one-cycle pulse on an undecodable instruction
bus_err  out  1  one-cycle pulse on memory wait timeout

Behaviour:
- Reset:
  - State is FETCH, wait counter is 0, latched opcode is 0.
  - While reset is high, every output is 0.
- Outputs are Moore, decoded from state only, except:
  - pc_en and ir_write in FETCH are gated by mem_ready.
  - pc_en in BRANCH is gated by zero.
- States, with asserted outputs (all others 0) and transitions:
  - FETCH: mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_en=mem_ready. Hold until mem_ready, then go to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Latch opcode. Dispatch: R-type with funct add -> EXEC_R; addi -> EXEC_I; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j -> JUMP; anything else -> illegal pulse, then FETCH.
  - EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next WB_R.
  - WB_R: reg_dst=1, reg_write. Next FETCH.
  - EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next WB_I.
  - WB_I: reg_dst=0, reg_write. Next FETCH.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next MEM_RD for lw, MEM_WR for sw.
  - MEM_RD: mem_read, iord=1. Hold until mem_ready, then WB_MEM.
  - WB_MEM: reg_dst=0, mem_to_reg=1, reg_write. Next FETCH.
  - MEM_WR: mem_write, iord=1. Hold until mem_ready, then FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01; pc_en = zero for beq, ~zero for bne. Next FETCH.
  - JUMP: pc_src=10, pc_en. Next FETCH.
- Latency with mem_ready held high:
  - beq, bne, j: 3 cycles
  - add, addi, sw: 4 cycles
  - lw: 5 cycles
- Wait counter:
  - Increments each cycle spent in FETCH, MEM_RD or MEM_WR with mem_ready=0.
  - Clears on state exit.
  - Saturates at 2^WAIT_W-1.
- Timeout (WAIT_MAX>0): if the counter reaches WAIT_MAX with mem_ready still 0:
  - Pulse bus_err and go to FETCH.
  - No IR, PC or register write occurs in that cycle.
- mem_ready asserted in a non-memory state is ignored.
- Reset asserted mid-instruction: next state is FETCH and no write enable asserts in the reset cycle.

Optional Feature:
- Macro: MIPS_CTRL_TRAP_EN.
- Defined: an illegal instruction or bus_err moves the FSM to TRAP.
  - TRAP holds all outputs 0 except illegal/bus_err, which are held high (sticky).
  - The FSM leaves TRAP only on reset.
- Undefined: both remain single-cycle pulses, the FSM returns to FETCH, and there is no TRAP state.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants OP_RTYPE=000000, OP_ADDI=001000, OP_LW=100011, OP_SW=101011, OP_J=000010, OP_BEQ=000100, OP_BNE=000101
  - funct constant FN_ADD=100000
  - ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT
  - pc_src and alu_src_b select encodings
  - state enum
- Sub-module mips_ctrl_decode: combinational opcode/funct -> dispatch target and illegal flag. The FSM and outputs stay in the top module.

Test Plan:
- mem_ready=1, add (op 000000, funct 100000) -> states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 with reg_dst=1 in cycle 4, alu_op=10 in cycle 3.
- lw with mem_ready low for 3 cycles in MEM_RD -> mem_read, iord=1 held for 4 cycles; WB_MEM asserts mem_to_reg=1 and reg_write=1 exactly once.
- beq with zero=1 and bne with zero=1 -> pc_en=1, pc_src=01 in BRANCH for beq; pc_en=0 for bne.
- Opcode 111111 -> illegal pulses 1 cycle in DECODE, next state FETCH; with MIPS_CTRL_TRAP_EN, stuck in TRAP with illegal=1 until reset.
- WAIT_MAX=3, mem_ready held 0 in FETCH -> bus_err pulses on the 3rd wait cycle, ir_write and pc_en never assert.
- Reset asserted during MEM_WR -> mem_write=0 that cycle, state_o=FETCH the next cycle.
